// File: rtl/uart_tx_if.sv
// Transmit-side handshake bundle for uart_tx: parallel byte in, serial line and
// frame-done pulse out.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] data;    // byte to send, sampled on the accept edge
  logic                 valid;   // request to send data
  logic                 ready;   // transmitter idle, can accept
  logic                 serial;  // serial line, idle high
  logic                 done;    // one-cycle pulse on the last stop-bit cycle

  // Producer side: offers bytes and watches the line.
  modport master (
    output data,
    output valid,
    input  ready,
    input  serial,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  data,
    input  valid,
    output ready,
    output serial,
    output done
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing, LSB first, idle-high line.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
// All outputs come straight from registers so the line never glitches.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4800,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_tx_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned     IdxW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  // Done is registered, so it is raised one cycle ahead of the final stop cycle.
  localparam logic [CntW-1:0] CntDone = CntW'(CLKS_PER_BIT - 2);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               r_state;
  logic [CntW-1:0]      r_clk_cnt;
  logic [IdxW-1:0]      r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_serial;
  logic                 r_ready;
  logic                 r_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic [DATA_BITS-1:0] w_shift_nxt;

  // Next data bit to put on the line once the current one has been held long enough.
  always_comb begin
    w_shift_nxt = r_shift >> 1;
  end

  // Frame sequencer: state, counters, shift register and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_serial  <= 1'b1;
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (bus.valid) begin
            // Start bit goes on the line the cycle after the accept edge.
            r_shift  <= bus.data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^bus.data;
`endif
            r_serial <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= StStart;
          end
        end
        StStart: begin
          if (r_clk_cnt == CntLast) begin
            r_clk_cnt <= '0;
            r_serial  <= r_shift[0];
            r_state   <= StData;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_clk_cnt == CntLast) begin
            r_clk_cnt <= '0;
            r_shift   <= w_shift_nxt;
            if (r_bit_idx == IdxLast) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_serial  <= r_parity;
              r_state   <= StParity;
`else
              r_serial  <= 1'b1;
              r_state   <= StStop;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_serial  <= w_shift_nxt[0];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StParity: begin
          if (r_clk_cnt == CntLast) begin
            r_clk_cnt <= '0;
            r_serial  <= 1'b1;
            r_state   <= StStop;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StStop: begin
          r_serial <= 1'b1;
          if (r_clk_cnt == CntDone) begin
            r_done <= 1'b1;
          end
          if (r_clk_cnt == CntLast) begin
            r_clk_cnt <= '0;
            r_ready   <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_serial  <= 1'b1;
          r_ready   <= 1'b1;
          r_clk_cnt <= '0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign bus.serial = r_serial;
  assign bus.ready  = r_ready;
  assign bus.done   = r_done;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter, 8N1 framing, LSB first. It is the transmit-side counterpart of the RX receiver and uses the same bit timing, so that a uart_tx serial output looped into RX reproduces the byte. It accepts one parallel byte through a valid/ready handshake and shifts it out on a single idle-high line. A one-cycle Done pulse marks the end of each frame.

Parameters:
CLKS_PER_BIT, 4800, number of Clock cycles per serial bit; must be at least 2. The default matches RX bit timing.
DATA_BITS, 8, data bits per frame.

Ports:
Clock  input  1  system clock; all logic on the rising edge.
Reset  input  1  asynchronous, active-high reset.
DataIn  input  DATA_BITS  byte to transmit; sampled only on the accept edge.
Valid  input  1  request to send DataIn.
Ready  output  1  high when a new byte can be accepted.
DataOut  output  1  serial line; idle high.
Done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset, asynchronous:
  - state=IDLE, DataOut=1, Ready=1, Done=0.
  - Bit counter, cycle counter and shift register are cleared.
- Ready is high exactly when state==IDLE. It is registered and glitch-free.
- Accept: a rising edge with state==IDLE and Valid=1.
  - DataIn is latched into the shift register.
  - state goes to START and Ready drops.
  - Valid while Ready=0 is ignored. DataIn changes after the accept edge have no effect.
- State machine, IDLE -> START -> DATA -> STOP -> IDLE.
  - START: DataOut=0 for CLKS_PER_BIT cycles.
  - DATA: DataOut = shift[0]. Shift right every CLKS_PER_BIT cycles. DATA_BITS bits are sent, LSB first.
  - STOP: DataOut=1 for CLKS_PER_BIT cycles. Done=1 on the final cycle of STOP, then state returns to IDLE.
- Timing:
  - The first start-bit cycle is the cycle after the accept edge.
  - Every bit lasts exactly CLKS_PER_BIT cycles, with no drift.
  - Frame length is (DATA_BITS+2)*CLKS_PER_BIT cycles.
- Cycle counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Width is $clog2(CLKS_PER_BIT).
  - The bit index counts 0..DATA_BITS-1.
- Back-to-back frames: if Valid is held high, the next accept happens on the first IDLE cycle. That gives exactly one idle-high cycle between stop and the next start.
- Reset mid-frame: DataOut returns to 1 immediately, with no partial stop bit. The frame is abandoned and Done is not pulsed.
- DataOut is driven from a register, so there are no combinational glitches on the line.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. It lasts CLKS_PER_BIT cycles.
  - DataOut during PARITY = XOR of the latched data bits (even parity).
  - Frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1 framing exactly as above.

Test Plan:
1. Reset, idle line (CLKS_PER_BIT=4): assert Reset for 2 cycles with Valid=0 for 20 cycles -> DataOut=1, Ready=1, Done=0 throughout.
2. Single byte (CLKS_PER_BIT=4, DataIn=8'hA5, Valid pulsed 1 cycle):
   - Line sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total.
   - Done is high only on cycle 40; Ready returns high on cycle 41.
3. Back-to-back (Valid held high, DataIn=8'h00 then 8'hFF):
   - Exactly 1 idle-high cycle between the two frames.
   - Second frame is 0, eight 1s, 1.
   - Valid and DataIn changes during frame 1 are ignored.
4. Reset mid-frame: assert Reset during data bit 3 of 8'h3C -> DataOut=1 and Ready=1 asynchronously; no Done pulse; the next accepted byte 8'h55 is transmitted correctly.
5. Loopback (default CLKS_PER_BIT=4800): DataOut tied to RX input, send 8'h55 then 8'hC3 -> RX DataOut shows 8'h55 then 8'hC3.
6. UART_TX_PARITY_EN defined, CLKS_PER_BIT=4:
   - 8'h07 -> parity bit 1; 8'h03 -> parity bit 0.
   - Each frame is 44 cycles; Done is on cycle 44.
